// File: rtl/redun_chk_rcv_pkg.sv
// Shared widths, FSM encoding and defaults for the receive-side redundancy checker.
// Widths follow NS_ADDRESS_SIZE / NS_DATA_SIZE / NS_REDUN_SIZE when those are defined.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 4
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

package redun_chk_rcv_pkg;

   localparam int ASZ_DEF = `NS_ADDRESS_SIZE;
   localparam int DSZ_DEF = `NS_DATA_SIZE;
   localparam int RSZ_DEF = `NS_REDUN_SIZE;

   localparam int CSZ_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_SEND  = 2'd2
   } state_t;

endpackage

// File: rtl/redun_chk_rcv_calc_redun.sv
// calc_redun: combinational partitioned-NAND redundancy over M = {src, dst, dat}.
// Each of the RSZ parts is NAND-reduced; the top part absorbs any remainder bits.
module redun_chk_rcv_calc_redun #(
   parameter int ASZ = 4,
   parameter int DSZ = 8,
   parameter int RSZ = 4
) (
   input  logic [ASZ-1:0] i_src,
   input  logic [ASZ-1:0] i_dst,
   input  logic [DSZ-1:0] i_dat,
   output logic [RSZ-1:0] o_red
);
   localparam int MSZ = 2*ASZ + DSZ;
   localparam int P   = MSZ / RSZ;

   logic [MSZ-1:0] w_msg;
   assign w_msg = {i_src, i_dst, i_dat};

   genvar g;
   generate
      for (g = 0; g < RSZ-1; g++) begin : g_part
         assign o_red[g] = ~&w_msg[g*P +: P];
      end
   endgenerate

   assign o_red[RSZ-1] = ~&w_msg[MSZ-1:(RSZ-1)*P];

endmodule

// File: rtl/redun_chk_rcv.sv
// Receive-side redundancy checker: capture on rcv_req/rcv_ack, recheck, forward or drop.
// NS_REDUN_ERR_CNT_EN adds the saturating err_cnt drop counter and its port.
module redun_chk_rcv
   import redun_chk_rcv_pkg::*;
#(
   parameter int ASZ = ASZ_DEF,
   parameter int DSZ = DSZ_DEF,
   parameter int RSZ = RSZ_DEF
`ifdef NS_REDUN_ERR_CNT_EN
   , parameter int CSZ = CSZ_DEF
`endif
) (
   input  logic           i_clk,
   input  logic           reset,
   input  logic           rcv_req,
   input  logic [ASZ-1:0] rcv_src,
   input  logic [ASZ-1:0] rcv_dst,
   input  logic [DSZ-1:0] rcv_dat,
   input  logic [RSZ-1:0] rcv_red,
   output logic           rcv_ack,
   output logic           snd_req,
   input  logic           snd_ack,
   output logic [ASZ-1:0] snd_src,
   output logic [ASZ-1:0] snd_dst,
   output logic [DSZ-1:0] snd_dat,
   output logic           err_pulse,
`ifdef NS_REDUN_ERR_CNT_EN
   output logic [CSZ-1:0] err_cnt,
`endif
   output state_t         dbg_state
);
   // Handshakes: a transfer happens on the rising edge where req=1 is sampled
   // (upstream) or where snd_req=1 and snd_ack=1 (downstream); rcv_ack is the
   // one-cycle capture pulse and snd_* holds steady while snd_req is high.
   state_t         r_state;
   logic [ASZ-1:0] r_src;
   logic [ASZ-1:0] r_dst;
   logic [DSZ-1:0] r_dat;
   logic [RSZ-1:0] r_red;
   logic [RSZ-1:0] w_red;
   logic           w_match;

   redun_chk_rcv_calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_calc_redun (
      .i_src (r_src),
      .i_dst (r_dst),
      .i_dat (r_dat),
      .o_red (w_red)
   );

   assign w_match   = (w_red == r_red);
   assign dbg_state = r_state;

   always_ff @(posedge i_clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_src     <= '0;
         r_dst     <= '0;
         r_dat     <= '0;
         r_red     <= '0;
         rcv_ack   <= 1'b0;
         snd_req   <= 1'b0;
         snd_src   <= '0;
         snd_dst   <= '0;
         snd_dat   <= '0;
         err_pulse <= 1'b0;
`ifdef NS_REDUN_ERR_CNT_EN
         err_cnt   <= '0;
`endif
      end else begin
         rcv_ack   <= 1'b0;
         err_pulse <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (rcv_req) begin
                  r_src   <= rcv_src;
                  r_dst   <= rcv_dst;
                  r_dat   <= rcv_dat;
                  r_red   <= rcv_red;
                  rcv_ack <= 1'b1;
                  r_state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (w_match) begin
                  snd_src <= r_src;
                  snd_dst <= r_dst;
                  snd_dat <= r_dat;
                  snd_req <= 1'b1;
                  r_state <= ST_SEND;
               end else begin
                  // Dropped: the buffer is simply overwritten by the next capture.
                  err_pulse <= 1'b1;
                  r_state   <= ST_IDLE;
`ifdef NS_REDUN_ERR_CNT_EN
                  if (err_cnt != '1) err_cnt <= err_cnt + CSZ'(1);
`endif
               end
            end
            ST_SEND: begin
               if (snd_ack) begin
                  snd_req <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
